// File: rtl/vga_sync_monitor_if.sv
// Pin bus and measurement results between a VGA generator side and the sync monitor.
interface vga_sync_monitor_if #(
    parameter int unsigned CNT_W = 11
);
    logic [7:0]       vga_in;
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_sync_len;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_sync_len;
    logic [15:0]      frame_sum;
    logic             frame_valid;
    logic             locked;
    logic [7:0]       frame_count;

    // Generator / harness side: drives pins, observes results
    modport master (
        output vga_in,
        input  h_total, h_sync_len, v_total, v_sync_len,
        input  frame_sum, frame_valid, locked, frame_count
    );

    // Monitor side: samples pins, reports results
    modport slave (
        input  vga_in,
        output h_total, h_sync_len, v_total, v_sync_len,
        output frame_sum, frame_valid, locked, frame_count
    );
endinterface

// File: rtl/vga_sync_monitor.sv
// Passive TinyVGA PMOD receiver: recovers line/frame timing, per-frame checksum and lock.
module vga_sync_monitor #(
    parameter bit          HSYNC_ACTIVE_LOW = 1'b1,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned CNT_W            = 11
) (
    input logic               clk,
    input logic               rst,
    vga_sync_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             hs_q, vs_q, hs_prev, vs_prev;
    logic [5:0]       pix_q;
    logic             h_armed, v_armed, snap_valid, frame_ok;
    logic [CNT_W-1:0] h_cnt, hl_cnt, v_cnt, vl_cnt;
    logic [CNT_W-1:0] h_total_q, h_sync_len_q, v_total_q, v_sync_len_q;
    logic [CNT_W-1:0] snap_h_total, snap_h_sync_len, snap_v_total, snap_v_sync_len;
    logic [15:0]      acc, frame_sum_q;
    logic             frame_valid_q, locked_q;
    logic [7:0]       frame_count_q;

    logic hs_rise_c, hs_fall_c, vs_rise_c, vs_fall_c;
    logic sat_c, h_bad_c, frame_close_c, timing_same_c;

    // Edge detection against previous sample; bad events spoil the current frame
    always_comb begin
        hs_rise_c     = hs_q & ~hs_prev;
        hs_fall_c     = ~hs_q & hs_prev;
        vs_rise_c     = vs_q & ~vs_prev;
        vs_fall_c     = ~vs_q & vs_prev;
        sat_c         = (h_cnt == CNT_MAX) | (hl_cnt == CNT_MAX) |
                        (v_cnt == CNT_MAX) | (vl_cnt == CNT_MAX);
        h_bad_c       = hs_rise_c & h_armed & (h_cnt != h_total_q);
        frame_close_c = vs_rise_c & v_armed;
        timing_same_c = (h_total_q == snap_h_total) & (h_sync_len_q == snap_h_sync_len) &
                        (v_cnt == snap_v_total) & (v_sync_len_q == snap_v_sync_len);
    end

    // Sample stage: polarity-normalised syncs and 6-bit pixel {R1,R0,G1,G0,B1,B0}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            pix_q   <= '0;
        end else begin
            hs_q    <= bus.vga_in[7] ^ HSYNC_ACTIVE_LOW;
            vs_q    <= bus.vga_in[3] ^ VSYNC_ACTIVE_LOW;
            hs_prev <= hs_q;
            vs_prev <= vs_q;
            pix_q   <= {bus.vga_in[0], bus.vga_in[4], bus.vga_in[1],
                        bus.vga_in[5], bus.vga_in[2], bus.vga_in[6]};
        end
    end

    // Horizontal timing: line period and hsync pulse width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_armed      <= 1'b0;
            h_cnt        <= '0;
            hl_cnt       <= '0;
            h_total_q    <= '0;
            h_sync_len_q <= '0;
        end else begin
            if (hs_rise_c) begin
                h_armed <= 1'b1;
                h_cnt   <= CNT_W'(1);
                if (h_armed) h_total_q <= h_cnt;
            end else if (h_armed && h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
            if (hs_rise_c) hl_cnt <= CNT_W'(1);
            else if (hs_q && hl_cnt != CNT_MAX) hl_cnt <= hl_cnt + CNT_W'(1);
            if (hs_fall_c) h_sync_len_q <= hl_cnt;
        end
    end

    // Vertical timing: line starts per frame and per vsync pulse; a coincident line start joins the new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_armed      <= 1'b0;
            v_cnt        <= '0;
            vl_cnt       <= '0;
            v_total_q    <= '0;
            v_sync_len_q <= '0;
        end else begin
            if (vs_rise_c) begin
                v_armed <= 1'b1;
                v_cnt   <= hs_rise_c ? CNT_W'(1) : '0;
                vl_cnt  <= hs_rise_c ? CNT_W'(1) : '0;
                if (v_armed) v_total_q <= v_cnt;
            end else begin
                if (v_armed && hs_rise_c && v_cnt != CNT_MAX) v_cnt <= v_cnt + CNT_W'(1);
                if (vs_q && hs_rise_c && vl_cnt != CNT_MAX) vl_cnt <= vl_cnt + CNT_W'(1);
            end
            if (vs_fall_c) v_sync_len_q <= vl_cnt;
        end
    end

    // Frame close: checksum, frame counter, consistency tracking and lock decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc             <= '0;
            frame_sum_q     <= '0;
            frame_valid_q   <= 1'b0;
            frame_count_q   <= '0;
            locked_q        <= 1'b0;
            frame_ok        <= 1'b0;
            snap_valid      <= 1'b0;
            snap_h_total    <= '0;
            snap_h_sync_len <= '0;
            snap_v_total    <= '0;
            snap_v_sync_len <= '0;
        end else begin
            frame_valid_q <= frame_close_c;
            if (vs_rise_c) acc <= '0;
            else if (!hs_q && !vs_q) acc <= acc + 16'(pix_q);
            if (vs_rise_c) frame_ok <= ~(h_bad_c | sat_c);
            else frame_ok <= frame_ok & ~(h_bad_c | sat_c);
            if (frame_close_c) begin
                frame_sum_q     <= acc;
                frame_count_q   <= frame_count_q + 8'd1;
                locked_q        <= snap_valid & frame_ok & timing_same_c;
                snap_valid      <= 1'b1;
                snap_h_total    <= h_total_q;
                snap_h_sync_len <= h_sync_len_q;
                snap_v_total    <= v_cnt;
                snap_v_sync_len <= v_sync_len_q;
            end
        end
    end

    assign bus.h_total     = h_total_q;
    assign bus.h_sync_len  = h_sync_len_q;
    assign bus.v_total     = v_total_q;
    assign bus.v_sync_len  = v_sync_len_q;
    assign bus.frame_sum   = frame_sum_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = locked_q;
    assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench: mini VGA mode into an active-low monitor and an active-high monitor fed inverted syncs.
module tb_vga_sync_monitor;
    localparam logic [7:0] IDLE = 8'h88;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] vin = IDLE;
    int n_checks = 0;
    int n_errors = 0;

    vga_sync_monitor_if #(.CNT_W(11)) bus_a ();
    vga_sync_monitor_if #(.CNT_W(11)) bus_b ();
    assign bus_a.vga_in = vin;
    assign bus_b.vga_in = vin ^ 8'h88;

    vga_sync_monitor #(.HSYNC_ACTIVE_LOW(1'b1), .VSYNC_ACTIVE_LOW(1'b1), .CNT_W(11))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    vga_sync_monitor #(.HSYNC_ACTIVE_LOW(1'b0), .VSYNC_ACTIVE_LOW(1'b0), .CNT_W(11))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Log of results seen at each frame_valid pulse, per monitor
    int          na = 0, nb = 0;
    int          lg_vt_a[64], lg_sum_a[64], lg_lock_a[64], lg_cnt_a[64];
    int          lg_sum_b[64], lg_lock_b[64];

    always @(negedge clk) begin
        if (bus_a.frame_valid === 1'b1 && na < 64) begin
            lg_vt_a[na]   = int'(bus_a.v_total);
            lg_sum_a[na]  = int'(bus_a.frame_sum);
            lg_lock_a[na] = int'(bus_a.locked);
            lg_cnt_a[na]  = int'(bus_a.frame_count);
            na++;
        end
    end

    always @(negedge clk) begin
        if (bus_b.frame_valid === 1'b1 && nb < 64) begin
            lg_sum_b[nb]  = int'(bus_b.frame_sum);
            lg_lock_b[nb] = int'(bus_b.locked);
            nb++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        vin = IDLE;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Mini mode: 20 clk lines, hsync 3, 10 lines, vsync 2 lines starting voff clocks into the frame
    task automatic gen(input int nfr, input int voff, input bit colour, input int long_fr,
                       input int stop_fr, input int stop_line);
        int         pos;
        int         ncol;
        logic [5:0] p;
        for (int f = 0; f < nfr; f++) begin
            for (int l = 0; l < 10; l++) begin
                if (f == stop_fr && l == stop_line) return;
                ncol = (f == long_fr && l == 5) ? 21 : 20;
                for (int c = 0; c < ncol; c++) begin
                    pos = l * 20 + c;
                    p = (colour && l >= 3 && l <= 8 && c >= 5 && c <= 16) ? 6'h3F : 6'h00;
                    @(negedge clk);
                    vin = {~(c < 3), p[0], p[2], p[4], ~(pos >= voff && pos < voff + 40),
                           p[1], p[3], p[5]};
                end
            end
        end
        @(negedge clk);
        vin = IDLE;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vin = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_a.h_total !== 11'd0 || bus_a.h_sync_len !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_h: got h_total=%0d h_sync_len=%0d expected 0 0", bus_a.h_total, bus_a.h_sync_len);
        end
        n_checks++;
        if (bus_a.v_total !== 11'd0 || bus_a.v_sync_len !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_v: got v_total=%0d v_sync_len=%0d expected 0 0", bus_a.v_total, bus_a.v_sync_len);
        end
        n_checks++;
        if (bus_a.frame_sum !== 16'd0 || bus_a.frame_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_sum: got frame_sum=%0h frame_valid=%b expected 0 0", bus_a.frame_sum, bus_a.frame_valid);
        end
        n_checks++;
        if (bus_a.locked !== 1'b0 || bus_a.frame_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_lock: got locked=%b frame_count=%0d expected 0 0", bus_a.locked, bus_a.frame_count);
        end
        n_checks++;
        if (bus_b.locked !== 1'b0 || bus_b.frame_count !== 8'd0 || bus_b.h_total !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_b: got locked=%b frame_count=%0d h_total=%0d expected 0 0 0",
                     bus_b.locked, bus_b.frame_count, bus_b.h_total);
        end
    endtask

    task automatic test_basic();
        int base;
        do_reset();
        base = na;
        gen(3, 5, 1'b0, -1, -1, -1);
        n_checks++;
        if (na - base !== 2) begin
            n_errors++;
            $display("FAIL basic_pulses: got %0d expected 2", na - base);
        end
        n_checks++;
        if (lg_vt_a[base] !== 10 || lg_cnt_a[base] !== 1 || lg_sum_a[base] !== 0) begin
            n_errors++;
            $display("FAIL basic_close1: got v_total=%0d count=%0d sum=%0d expected 10 1 0",
                     lg_vt_a[base], lg_cnt_a[base], lg_sum_a[base]);
        end
        n_checks++;
        if (lg_vt_a[base+1] !== 10 || lg_cnt_a[base+1] !== 2 || lg_lock_a[base+1] !== 1) begin
            n_errors++;
            $display("FAIL basic_close2: got v_total=%0d count=%0d locked=%0d expected 10 2 1",
                     lg_vt_a[base+1], lg_cnt_a[base+1], lg_lock_a[base+1]);
        end
        n_checks++;
        if (bus_a.h_total !== 11'd20) begin
            n_errors++;
            $display("FAIL basic_h_total: got %0d expected 20", bus_a.h_total);
        end
        n_checks++;
        if (bus_a.h_sync_len !== 11'd3) begin
            n_errors++;
            $display("FAIL basic_h_sync_len: got %0d expected 3", bus_a.h_sync_len);
        end
        n_checks++;
        if (bus_a.v_sync_len !== 11'd2) begin
            n_errors++;
            $display("FAIL basic_v_sync_len: got %0d expected 2", bus_a.v_sync_len);
        end
        n_checks++;
        if (bus_a.frame_count !== 8'd2 || bus_a.locked !== 1'b1 || bus_a.frame_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_final: got count=%0d locked=%b valid=%b expected 2 1 0",
                     bus_a.frame_count, bus_a.locked, bus_a.frame_valid);
        end
    endtask

    task automatic test_checksum();
        int base;
        do_reset();
        base = na;
        gen(3, 5, 1'b1, -1, -1, -1);
        n_checks++;
        if (na - base !== 2) begin
            n_errors++;
            $display("FAIL sum_pulses: got %0d expected 2", na - base);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (lg_sum_a[base+i] !== 32'h11B8) begin
                n_errors++;
                $display("FAIL sum_frame%0d: got %0h expected 11b8", i, lg_sum_a[base+i]);
            end
        end
    endtask

    task automatic test_long_line();
        int base;
        do_reset();
        base = na;
        gen(6, 5, 1'b0, 2, -1, -1);
        n_checks++;
        if (na - base !== 5) begin
            n_errors++;
            $display("FAIL long_pulses: got %0d expected 5", na - base);
        end
        n_checks++;
        if (lg_lock_a[base+1] !== 1) begin
            n_errors++;
            $display("FAIL long_lock_before: got %0d expected 1", lg_lock_a[base+1]);
        end
        n_checks++;
        if (lg_lock_a[base+2] !== 0 || lg_vt_a[base+2] !== 10) begin
            n_errors++;
            $display("FAIL long_lock_drop: got locked=%0d v_total=%0d expected 0 10",
                     lg_lock_a[base+2], lg_vt_a[base+2]);
        end
        n_checks++;
        if (lg_lock_a[base+4] !== 1 || lg_cnt_a[base+4] !== 5) begin
            n_errors++;
            $display("FAIL long_lock_back: got locked=%0d count=%0d expected 1 5",
                     lg_lock_a[base+4], lg_cnt_a[base+4]);
        end
    endtask

    task automatic test_aligned();
        int base;
        do_reset();
        base = na;
        gen(3, 0, 1'b0, -1, -1, -1);
        n_checks++;
        if (na - base !== 2) begin
            n_errors++;
            $display("FAIL aligned_pulses: got %0d expected 2", na - base);
        end
        n_checks++;
        if (lg_vt_a[base] !== 10 || lg_vt_a[base+1] !== 10) begin
            n_errors++;
            $display("FAIL aligned_v_total: got %0d %0d expected 10 10", lg_vt_a[base], lg_vt_a[base+1]);
        end
        n_checks++;
        if (bus_a.v_sync_len !== 11'd2 || bus_a.locked !== 1'b1) begin
            n_errors++;
            $display("FAIL aligned_final: got v_sync_len=%0d locked=%b expected 2 1", bus_a.v_sync_len, bus_a.locked);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        gen(2, 5, 1'b1, -1, 1, 5);
        n_checks++;
        if (bus_a.frame_count !== 8'd1) begin
            n_errors++;
            $display("FAIL midrst_pre: got frame_count=%0d expected 1", bus_a.frame_count);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus_a.h_total, bus_a.h_sync_len, bus_a.v_total, bus_a.v_sync_len} !== 44'd0 ||
            {bus_a.frame_sum, bus_a.frame_valid, bus_a.locked, bus_a.frame_count} !== 26'd0) begin
            n_errors++;
            $display("FAIL midrst_zero: got h=%0d hs=%0d v=%0d vs=%0d sum=%0h cnt=%0d expected all 0",
                     bus_a.h_total, bus_a.h_sync_len, bus_a.v_total, bus_a.v_sync_len,
                     bus_a.frame_sum, bus_a.frame_count);
        end
        vin = IDLE;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = na;
        gen(1, 5, 1'b1, -1, -1, -1);
        n_checks++;
        if (na - base !== 0 || bus_a.frame_count !== 8'd0) begin
            n_errors++;
            $display("FAIL midrst_arm_only: got pulses=%0d count=%0d expected 0 0", na - base, bus_a.frame_count);
        end
        gen(1, 5, 1'b1, -1, -1, -1);
        n_checks++;
        if (na - base !== 1 || bus_a.frame_count !== 8'd1) begin
            n_errors++;
            $display("FAIL midrst_close: got pulses=%0d count=%0d expected 1 1", na - base, bus_a.frame_count);
        end
        n_checks++;
        if (bus_a.v_total !== 11'd10 || bus_a.frame_sum !== 16'h11B8) begin
            n_errors++;
            $display("FAIL midrst_frame: got v_total=%0d sum=%0h expected 10 11b8", bus_a.v_total, bus_a.frame_sum);
        end
    endtask

    task automatic test_polarity();
        int base;
        do_reset();
        base = nb;
        gen(3, 5, 1'b1, -1, -1, -1);
        n_checks++;
        if (nb - base !== 2 || lg_sum_b[base] !== 32'h11B8 || lg_sum_b[base+1] !== 32'h11B8) begin
            n_errors++;
            $display("FAIL pol_frames: got pulses=%0d sums=%0h %0h expected 2 11b8 11b8",
                     nb - base, lg_sum_b[base], lg_sum_b[base+1]);
        end
        n_checks++;
        if (lg_lock_b[base+1] !== 1) begin
            n_errors++;
            $display("FAIL pol_lock_close: got %0d expected 1", lg_lock_b[base+1]);
        end
        n_checks++;
        if (bus_b.h_total !== 11'd20 || bus_b.h_sync_len !== 11'd3) begin
            n_errors++;
            $display("FAIL pol_h: got h_total=%0d h_sync_len=%0d expected 20 3", bus_b.h_total, bus_b.h_sync_len);
        end
        n_checks++;
        if (bus_b.v_total !== 11'd10 || bus_b.v_sync_len !== 11'd2) begin
            n_errors++;
            $display("FAIL pol_v: got v_total=%0d v_sync_len=%0d expected 10 2", bus_b.v_total, bus_b.v_sync_len);
        end
        n_checks++;
        if (bus_b.frame_count !== 8'd2 || bus_b.locked !== 1'b1) begin
            n_errors++;
            $display("FAIL pol_final: got count=%0d locked=%b expected 2 1", bus_b.frame_count, bus_b.locked);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_checksum();
        test_long_line();
        test_aligned();
        test_mid_reset();
        test_polarity();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
